// File: rtl/lif_accumulator_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : lif_accumulator_pkg
// Purpose : Shared definitions for the leaky integrate-and-fire stage.
//           - lif_state_e : FSM state encodings (ST_INTEG / ST_REFRAC)
//           - cnt_width() : width of the refractory down-counter
// Revision: 1.0  initial release
// ============================================================================
package lif_accumulator_pkg;

    typedef enum logic [0:0] {
        ST_INTEG  = 1'b0,
        ST_REFRAC = 1'b1
    } lif_state_e;

    // Bits needed to hold values 0..refrac_cyc. The result is clamped to at
    // least 1 so that a zero refractory period still gives a legal vector.
    function automatic int cnt_width(input int refrac_cyc);
        if (refrac_cyc < 1) begin
            return 1;
        end
        return $clog2(refrac_cyc + 1);
    endfunction

endpackage : lif_accumulator_pkg
`default_nettype wire

// File: rtl/lif_accumulator_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : nbit_adder
// Purpose : Unsigned n-bit ripple-carry adder with carry-out.
// Ports   : a   [n-1:0] in   first operand
//           b   [n-1:0] in   second operand
//           sum [n:0]   out  a + b, sum[n] is the carry-out
// Revision: 1.0  initial release
// ============================================================================
module nbit_adder #(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n:0]   sum
);

    logic [n:0] w_carry;

    assign w_carry[0] = 1'b0;

    for (genvar i = 0; i < n; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign sum[n] = w_carry[n];

endmodule : nbit_adder
`default_nettype wire

// File: rtl/lif_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : lif_accumulator
// Purpose : Leaky integrate-and-fire membrane stage. Weighted events arrive on
//           a valid/ready handshake and are added (saturating) to the membrane
//           register; leak_tick subtracts membrane>>LEAK_SHIFT; crossing the
//           threshold fires a one-cycle spike, clears the membrane and holds
//           off input for REFRAC_CYC cycles.
// Ports   : clk        in   1        rising-edge clock
//           rst_n      in   1        asynchronous active-low reset
//           in_valid   in   1        input weight valid
//           in_ready   out  1        weight can be accepted this cycle
//           in_weight  in   WIDTH    unsigned weight
//           leak_tick  in   1        one-cycle leak request
//           threshold  in   WIDTH+1  fire level (> 2^WIDTH-1 disables firing)
//           membrane   out  WIDTH    registered membrane potential
//           spike      out  1        registered one-cycle fire pulse
//           refrac     out  1        high while refractory
// Revision: 1.0  initial release
// ============================================================================
module lif_accumulator
    import lif_accumulator_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int LEAK_SHIFT = 2,
    parameter int REFRAC_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_weight,
    input  logic             leak_tick,
    input  logic [WIDTH:0]   threshold,
    output logic [WIDTH-1:0] membrane,
    output logic             spike,
    output logic             refrac
);

    localparam int               C_CNT_W  = cnt_width(REFRAC_CYC);
    localparam logic [C_CNT_W-1:0] C_REFRAC = C_CNT_W'(REFRAC_CYC);
    localparam logic [WIDTH-1:0] C_MAX    = '1;

    lif_state_e         state_q, state_d;
    logic [C_CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0]   membrane_q, membrane_d;
    logic               spike_q, spike_d;
    logic               leak_pending_q, leak_pending_d;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_sat;
    logic [WIDTH-1:0]   w_leaked;
    logic               w_transfer;
    logic               w_fire;

    nbit_adder #(.n(WIDTH)) u_adder (
        .a   (membrane_q),
        .b   (in_weight),
        .sum (w_sum)
    );

    assign w_sat      = w_sum[WIDTH] ? C_MAX : w_sum[WIDTH-1:0];
    // Subtracting a right-shifted copy of itself can never underflow.
    assign w_leaked   = membrane_q - (membrane_q >> LEAK_SHIFT);

    // in_ready is purely combinational from state, so it reads 1 while reset
    // is asserted; transfers are still blocked because the flops are held.
    assign in_ready   = (state_q == ST_INTEG) && !leak_pending_q;
    assign w_transfer = in_valid && in_ready;
    assign w_fire     = w_transfer && ({1'b0, w_sat} >= threshold);

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        membrane_d     = membrane_q;
        spike_d        = 1'b0;
        leak_pending_d = leak_pending_q;

        unique case (state_q)
            ST_INTEG: begin
                if (w_fire) begin
                    membrane_d     = '0;
                    spike_d        = 1'b1;
                    leak_pending_d = 1'b0;
                    if (REFRAC_CYC > 0) begin
                        state_d = ST_REFRAC;
                        count_d = C_REFRAC;
                    end
                end else if (w_transfer) begin
                    membrane_d = w_sat;
                    // The adder is busy with the weight; defer the leak one cycle.
                    if (leak_tick) begin
                        leak_pending_d = 1'b1;
                    end
                end else if (leak_pending_q) begin
                    // A tick arriving now merges with the deferred one.
                    membrane_d     = w_leaked;
                    leak_pending_d = 1'b0;
                end else if (leak_tick) begin
                    membrane_d = w_leaked;
                end
            end

            ST_REFRAC: begin
                membrane_d = '0;
                count_d    = count_q - 1'b1;
                if (count_q == C_CNT_W'(1)) begin
                    state_d = ST_INTEG;
                end
            end

            default: begin
                state_d = ST_INTEG;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_INTEG;
            count_q        <= '0;
            membrane_q     <= '0;
            spike_q        <= 1'b0;
            leak_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            membrane_q     <= membrane_d;
            spike_q        <= spike_d;
            leak_pending_q <= leak_pending_d;
        end
    end

    assign membrane = membrane_q;
    assign spike    = spike_q;
    assign refrac   = (state_q == ST_REFRAC);

endmodule : lif_accumulator
`default_nettype wire

// File: tb/tb_lif_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_lif_accumulator
// Purpose : Directed self-checking bench for lif_accumulator
//           (WIDTH=4, LEAK_SHIFT=2, REFRAC_CYC=2) with hand-computed values.
// Revision: 1.0  initial release
// ============================================================================
module tb_lif_accumulator;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_weight;
    logic             leak_tick;
    logic [WIDTH:0]   threshold;
    logic [WIDTH-1:0] membrane;
    logic             spike;
    logic             refrac;

    int checks = 0;
    int errors = 0;

    lif_accumulator #(
        .WIDTH      (4),
        .LEAK_SHIFT (2),
        .REFRAC_CYC (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_weight (in_weight),
        .leak_tick (leak_tick),
        .threshold (threshold),
        .membrane  (membrane),
        .spike     (spike),
        .refrac    (refrac)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [7:0] m, input logic s,
                             input logic r, input logic rdy);
        chk({tag, ".membrane"}, 8'(membrane), m);
        chk({tag, ".spike"},    8'(spike),    8'(s));
        chk({tag, ".refrac"},   8'(refrac),   8'(r));
        chk({tag, ".in_ready"}, 8'(in_ready), 8'(rdy));
    endtask

    // Asynchronous reset pulse taken and released between clock edges.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_state("rst", 8'd0, 1'b0, 1'b0, 1'b1);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_weight = '0;
        leak_tick = 1'b0;
        threshold = 5'd16;

        // ---- 1: reset mid-run, outputs clear without a clock edge ----
        tick();
        in_valid = 1'b1; in_weight = 4'd4;
        tick();
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("t1_async", 8'd0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_state("t1_held", 8'd0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;

        // ---- 2: integrate 3,3,3,3 against threshold 10 ----
        threshold = 5'd10;
        in_valid = 1'b1; in_weight = 4'd3;
        tick(); chk_state("t2_w1", 8'd3, 1'b0, 1'b0, 1'b1);
        tick(); chk_state("t2_w2", 8'd6, 1'b0, 1'b0, 1'b1);
        tick(); chk_state("t2_w3", 8'd9, 1'b0, 1'b0, 1'b1);
        tick(); chk_state("t2_fire", 8'd0, 1'b1, 1'b1, 1'b0);
        in_valid = 1'b0;
        tick(); chk_state("t2_ref1", 8'd0, 1'b0, 1'b1, 1'b0);
        tick(); chk_state("t2_done", 8'd0, 1'b0, 1'b0, 1'b1);

        // ---- 3: saturation on carry-out ----
        do_reset();
        threshold = 5'd16;
        in_valid = 1'b1; in_weight = 4'd9;
        tick(); chk_state("t3_w1", 8'd9, 1'b0, 1'b0, 1'b1);
        tick(); chk_state("t3_sat", 8'd15, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        tick(); chk_state("t3_hold", 8'd15, 1'b0, 1'b0, 1'b1);

        // ---- 4: leak, then deferred leak behind a transfer ----
        do_reset();
        in_valid = 1'b1; in_weight = 4'd12;
        tick(); chk("t4_load", 8'(membrane), 8'd12);
        in_valid = 1'b0; leak_tick = 1'b1;
        tick(); chk("t4_leak1", 8'(membrane), 8'd9);
        tick(); chk("t4_leak2", 8'(membrane), 8'd7);
        in_valid = 1'b1; in_weight = 4'd1;
        tick(); chk_state("t4_xfer", 8'd8, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0; leak_tick = 1'b0;
        tick(); chk_state("t4_pend", 8'd6, 1'b0, 1'b0, 1'b1);
        tick(); chk("t4_idle", 8'(membrane), 8'd6);

        // ---- 5: threshold 0 fires on weight 0; leak ignored in refractory ----
        threshold = 5'd0;
        in_valid = 1'b1; in_weight = 4'd0;
        tick(); chk_state("t5_fire", 8'd0, 1'b1, 1'b1, 1'b0);
        in_valid = 1'b0; leak_tick = 1'b1;
        tick(); chk_state("t5_ref1", 8'd0, 1'b0, 1'b1, 1'b0);
        leak_tick = 1'b0;
        tick(); chk_state("t5_done", 8'd0, 1'b0, 1'b0, 1'b1);

        // ---- 6: reset while refractory count is 1 ----
        in_valid = 1'b1; in_weight = 4'd0;
        tick(); chk("t6_refrac", 8'(refrac), 8'd1);
        in_valid = 1'b0;
        tick(); chk("t6_cnt1", 8'(refrac), 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("t6_async", 8'd0, 1'b0, 1'b0, 1'b1);
        tick();
        rst_n = 1'b1;
        threshold = 5'd16;
        in_valid = 1'b1; in_weight = 4'd5;
        tick(); chk_state("t6_w5", 8'd5, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_lif_accumulator
`default_nettype wire
